iaq_chan_sched: RTL and testbench

Round-robin scheduler that time-shares one combinational inverse adaptive quantizer (I, Y, RATE → D) among NCH ADPCM channel requesters in the multi-channel codec. It grants one requester per cycle and registers that channel's operands onto the shared datapath inputs. It then registers the datapath result and returns it tagged with the channel number. Throughput is one conversion per cycle, with a fixed two-cycle latency from grant to result.

---
 rtl/iaq_sched_pkg.sv | 16 +
 rtl/iaq_chan_sched_rr_arb.sv | 30 +++
 rtl/iaq_chan_sched.sv | 114 +++++++++++
 tb/tb_iaq_chan_sched.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/iaq_sched_pkg.sv
// Shared widths, default channel count and pointer-wrap helper for the
// inverse adaptive quantizer channel scheduler.
package iaq_sched_pkg;

    localparam int I_W     = 5;
    localparam int Y_W     = 13;
    localparam int RATE_W  = 2;
    localparam int D_W     = 16;
    localparam int NCH_DEF = 4;

    // Round-robin pointer advance: one past the granted channel, wrapping at nch.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned nch);
        return (ptr >= nch - 1) ? 0 : ptr + 1;
    endfunction

endpackage

// File: rtl/iaq_chan_sched_rr_arb.sv
// Combinational round-robin arbiter: picks the first eligible channel at or
// after the pointer, wrapping from NCH-1 to 0; returns one-hot and encoded id.
module rr_arb #(
    parameter int NCH = 4,
    parameter int CW  = $clog2(NCH)
) (
    input  logic [NCH-1:0] elig_i,
    input  logic [CW-1:0]  ptr_i,
    output logic [NCH-1:0] gnt_o,
    output logic [CW-1:0]  id_o
);

    always_comb begin
        logic found;
        int   idx;
        gnt_o = '0;
        id_o  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 0; i < NCH; i++) begin
            idx = (int'(ptr_i) + i) % NCH;
            if (!found && elig_i[idx]) begin
                found      = 1'b1;
                gnt_o[idx] = 1'b1;
                id_o       = CW'(idx);
            end
        end
    end

endmodule

// File: rtl/iaq_chan_sched.sv
// Round-robin time-sharing of one inverse adaptive quantizer among NCH channels.
// Optional per-frame fairness and overrun flag via `define IAQ_SCHED_FRAME_EN.
module iaq_chan_sched
    import iaq_sched_pkg::*;
#(
    parameter int NCH = NCH_DEF,
    parameter int CW  = $clog2(NCH)
) (
    input  logic                  CLK,
    input  logic                  RESET,
    input  logic [NCH-1:0]        REQ,
    input  logic [NCH*I_W-1:0]    I_IN,
    input  logic [NCH*Y_W-1:0]    Y_IN,
    input  logic [NCH*RATE_W-1:0] RATE_IN,
    output logic [NCH-1:0]        GNT,
    output logic [I_W-1:0]        Q_I,
    output logic [Y_W-1:0]        Q_Y,
    output logic [RATE_W-1:0]     Q_RATE,
    input  logic [D_W-1:0]        Q_D,
    output logic [D_W-1:0]        D_OUT,
    output logic                  D_VLD,
    output logic [CW-1:0]         D_CH,
    input  logic                  FS,
    output logic                  OVR
);

    logic [NCH-1:0] mask, elig, arb_gnt, gnt;
    logic [CW-1:0]  arb_id, ptr_q, ptr_d, c1_q, d_ch_q;
    logic           any_gnt, v1_q, d_vld_q;
    logic [I_W-1:0]    qi_q;
    logic [Y_W-1:0]    qy_q;
    logic [RATE_W-1:0] qr_q;
    logic [D_W-1:0]    d_out_q;

    assign elig = REQ & ~mask;

    rr_arb #(.NCH(NCH), .CW(CW)) u_arb (
        .elig_i (elig),
        .ptr_i  (ptr_q),
        .gnt_o  (arb_gnt),
        .id_o   (arb_id)
    );

    // Reset blocks acceptance so no requester believes it was served.
    assign gnt     = RESET ? '0 : arb_gnt;
    assign any_gnt = |gnt;
    assign GNT     = gnt;
    assign ptr_d   = any_gnt ? CW'(next_ptr(32'(arb_id), 32'(NCH))) : ptr_q;

    always_ff @(posedge CLK) begin
        if (RESET) begin
            ptr_q   <= '0;
            v1_q    <= 1'b0;
            c1_q    <= '0;
            qi_q    <= '0;
            qy_q    <= '0;
            qr_q    <= '0;
            d_vld_q <= 1'b0;
            d_out_q <= '0;
            d_ch_q  <= '0;
        end else begin
            ptr_q <= ptr_d;
            v1_q  <= any_gnt;
            if (any_gnt) begin
                c1_q <= arb_id;
                qi_q <= I_IN[arb_id*I_W +: I_W];
                qy_q <= Y_IN[arb_id*Y_W +: Y_W];
                qr_q <= RATE_IN[arb_id*RATE_W +: RATE_W];
            end
            d_vld_q <= v1_q;
            d_out_q <= Q_D;
            d_ch_q  <= c1_q;
        end
    end

    assign Q_I    = qi_q;
    assign Q_Y    = qy_q;
    assign Q_RATE = qr_q;
    assign D_OUT  = d_out_q;
    assign D_VLD  = d_vld_q;
    assign D_CH   = d_ch_q;

`ifdef IAQ_SCHED_FRAME_EN
    logic [NCH-1:0] served_q, served_d;
    logic           ovr_q, ovr_d;

    assign mask = served_q;

    // A grant coinciding with FS is accepted but does not count toward the new frame.
    always_comb begin
        served_d = FS ? '0 : (served_q | gnt);
        ovr_d    = ovr_q | (FS & |(REQ & ~served_q));
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            served_q <= '0;
            ovr_q    <= 1'b0;
        end else begin
            served_q <= served_d;
            ovr_q    <= ovr_d;
        end
    end

    assign OVR = ovr_q;
`else
    logic unused_fs;

    assign mask      = '0;
    assign OVR       = 1'b0;
    assign unused_fs = FS;
`endif

endmodule

// File: tb/tb_iaq_chan_sched.sv
// Directed bench for iaq_chan_sched with the stub datapath Q_D = {Q_I, Q_Y[10:0]};
// the frame section follows whichever IAQ_SCHED_FRAME_EN build is compiled.
module tb_iaq_chan_sched;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  REQ;
    logic [19:0] I_IN;
    logic [51:0] Y_IN;
    logic [7:0]  RATE_IN;
    logic [3:0]  GNT;
    logic [4:0]  Q_I;
    logic [12:0] Q_Y;
    logic [1:0]  Q_RATE;
    logic [15:0] Q_D;
    logic [15:0] D_OUT;
    logic        D_VLD;
    logic [1:0]  D_CH;
    logic        FS;
    logic        OVR;

    int n_tests = 0;
    int n_fail  = 0;

    logic [15:0] dexp [4];

    iaq_chan_sched #(.NCH(4)) dut (
        .CLK(CLK), .RESET(RESET), .REQ(REQ), .I_IN(I_IN), .Y_IN(Y_IN),
        .RATE_IN(RATE_IN), .GNT(GNT), .Q_I(Q_I), .Q_Y(Q_Y), .Q_RATE(Q_RATE),
        .Q_D(Q_D), .D_OUT(D_OUT), .D_VLD(D_VLD), .D_CH(D_CH), .FS(FS), .OVR(OVR)
    );

    assign Q_D = {Q_I, Q_Y[10:0]};

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic set_ch(input int k, input logic [4:0] i, input logic [12:0] y, input logic [1:0] r);
        I_IN[k*5 +: 5]     = i;
        Y_IN[k*13 +: 13]   = y;
        RATE_IN[k*2 +: 2]  = r;
    endtask

    initial begin
        RESET = 1'b1; REQ = 4'b1111; FS = 1'b0;
        I_IN = '0; Y_IN = '0; RATE_IN = '0;
        #1;
        chk("gnt_forced_in_reset", 32'(GNT), 32'h0);
        tick(); tick();
        chk("rst_d_vld",  32'(D_VLD),  32'h0);
        chk("rst_d_out",  32'(D_OUT),  32'h0);
        chk("rst_d_ch",   32'(D_CH),   32'h0);
        chk("rst_q_i",    32'(Q_I),    32'h0);
        chk("rst_q_y",    32'(Q_Y),    32'h0);
        chk("rst_q_rate", 32'(Q_RATE), 32'h0);
        chk("rst_ovr",    32'(OVR),    32'h0);
        REQ = 4'b0000;
        RESET = 1'b0;
        tick();

        // Single request on channel 0
        set_ch(0, 5'h13, 13'h00A5, 2'b10);
        REQ = 4'b0001;
        #1;
        chk("single_gnt", 32'(GNT), 32'h1);
        tick();
        REQ = 4'b0000;
        chk("single_q_i",    32'(Q_I),    32'h13);
        chk("single_q_y",    32'(Q_Y),    32'h00A5);
        chk("single_q_rate", 32'(Q_RATE), 32'h2);
        chk("single_vld_t1", 32'(D_VLD),  32'h0);
        tick();
        chk("single_vld_t2", 32'(D_VLD),  32'h1);
        chk("single_d_out",  32'(D_OUT),  32'h98A5);
        chk("single_d_ch",   32'(D_CH),   32'h0);
        tick();
        chk("single_vld_t3", 32'(D_VLD),  32'h0);

        // Restore PTR=0, then all four channels requesting for 8 cycles
        RESET = 1'b1; tick(); RESET = 1'b0;
        set_ch(0, 5'h01, 13'h0001, 2'b00); dexp[0] = 16'h0801;
        set_ch(1, 5'h02, 13'h0123, 2'b01); dexp[1] = 16'h1123;
        set_ch(2, 5'h1F, 13'h1FFF, 2'b10); dexp[2] = 16'hFFFF;
        set_ch(3, 5'h0A, 13'h0555, 2'b11); dexp[3] = 16'h5555;
        for (int c = 0; c < 10; c++) begin
            REQ = (c < 8) ? 4'b1111 : 4'b0000;
            #1;
            chk($sformatf("rr_gnt_c%0d", c), 32'(GNT), (c < 8) ? (32'h1 << (c % 4)) : 32'h0);
            if (c >= 2) begin
                chk($sformatf("rr_vld_c%0d", c), 32'(D_VLD), 32'h1);
                chk($sformatf("rr_ch_c%0d", c),  32'(D_CH),  32'((c - 2) % 4));
                chk($sformatf("rr_d_c%0d", c),   32'(D_OUT), 32'(dexp[(c - 2) % 4]));
            end
            tick();
        end
        chk("rr_vld_drain", 32'(D_VLD), 32'h0);

        // Skip over idle channels with wrap
        REQ = 4'b0010; #1;
        chk("skip_gnt_ch1", 32'(GNT), 32'h2);
        tick();
        REQ = 4'b1010; #1;
        chk("skip_gnt_ch3", 32'(GNT), 32'h8);
        tick(); #1;
        chk("skip_gnt_ch1_again", 32'(GNT), 32'h2);
        tick();

        // Reset in the middle of a stream (PTR=2 here)
        REQ = 4'b1111; #1;
        chk("mid_gnt_a", 32'(GNT), 32'h4);
        tick(); #1;
        chk("mid_gnt_b", 32'(GNT), 32'h8);
        tick();
        RESET = 1'b1; #1;
        chk("mid_gnt_forced", 32'(GNT),   32'h0);
        chk("mid_vld_pre",    32'(D_VLD), 32'h1);
        chk("mid_ch_pre",     32'(D_CH),  32'h2);
        chk("mid_d_pre",      32'(D_OUT), 32'hFFFF);
        tick();
        RESET = 1'b0;
        REQ = 4'b1010; #1;
        chk("mid_vld_post1",  32'(D_VLD), 32'h0);
        chk("mid_gnt_lowest", 32'(GNT),   32'h2);
        tick();
        REQ = 4'b0000;
        chk("mid_vld_post2",  32'(D_VLD), 32'h0);
        tick();
        chk("mid_vld_new",    32'(D_VLD), 32'h1);
        chk("mid_ch_new",     32'(D_CH),  32'h1);
        chk("mid_d_new",      32'(D_OUT), 32'h1123);

        // Frame handling
        RESET = 1'b1; tick(); RESET = 1'b0;
        REQ = 4'b0100; #1;
        chk("frm_gnt_first", 32'(GNT), 32'h4);
        tick(); #1;
`ifdef IAQ_SCHED_FRAME_EN
        chk("frm_gnt_masked", 32'(GNT), 32'h0);
`else
        chk("frm_gnt_unmasked", 32'(GNT), 32'h4);
`endif
        tick();
        chk("frm_ovr_before", 32'(OVR), 32'h0);
        REQ = 4'b0101; FS = 1'b1; #1;
        chk("frm_gnt_at_fs", 32'(GNT), 32'h1);
        tick();
        FS = 1'b0; REQ = 4'b0100; #1;
`ifdef IAQ_SCHED_FRAME_EN
        chk("frm_ovr_set", 32'(OVR), 32'h1);
`else
        chk("frm_ovr_tied", 32'(OVR), 32'h0);
`endif
        chk("frm_gnt_new_frame", 32'(GNT), 32'h4);
        tick();
        REQ = 4'b0000;
        tick();
`ifdef IAQ_SCHED_FRAME_EN
        chk("frm_ovr_sticky", 32'(OVR), 32'h1);
`else
        chk("frm_ovr_still0", 32'(OVR), 32'h0);
`endif
        RESET = 1'b1; tick(); RESET = 1'b0;
        chk("frm_ovr_cleared", 32'(OVR), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
